// File: rtl/div_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : div_if
//  Description : Request/response bundle between the EX stage (master) and
//                the multi-cycle integer divider (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  start;
    logic                  is_signed;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic                  cancel;
    logic                  busy;
    logic                  result_valid;
    logic [2*DATA_W-1:0]   result;

    modport master (
        output start, is_signed, a, b, cancel,
        input  busy, result_valid, result
    );

    modport slave (
        input  start, is_signed, a, b, cancel,
        output busy, result_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Radix-2 restoring integer divider for DIV/DIVU. Returns
//                {remainder, quotient} in HI/LO layout. One quotient bit per
//                clock, then a single sign-correction cycle.
//  Options     : DIV_ZERO_FAST_EN - when defined, a zero divisor skips the
//                iteration phase and goes straight to sign correction.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    localparam int                CNT_W       = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  c_LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_busy;
    logic                 w_valid;

    // Operand magnitudes and sign bookkeeping captured with start
    logic [DATA_W-1:0]    r_rem;
    logic [DATA_W-1:0]    r_quo;
    logic [DATA_W-1:0]    r_div;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*DATA_W-1:0]  r_result;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [DATA_W-1:0]    w_a_mag;
    logic [DATA_W-1:0]    w_b_mag;
    logic [DATA_W:0]      w_upper;
    logic [DATA_W:0]      w_trial;
    logic                 w_trial_neg;
    logic [DATA_W-1:0]    w_q_fix;
    logic [DATA_W-1:0]    w_r_fix;

`ifdef DIV_ZERO_FAST_EN
    logic                 w_b_zero;
    assign w_b_zero = (bus.b == '0);
`endif

    // Magnitudes are only taken for signed requests; DIVU uses raw operands
    assign w_a_neg = bus.is_signed & bus.a[DATA_W-1];
    assign w_b_neg = bus.is_signed & bus.b[DATA_W-1];
    assign w_a_mag = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag = w_b_neg ? -bus.b : bus.b;

    // Restoring step. The partial remainder is always below the divisor, so
    // the shifted value is below 2*divisor and a DATA_W+1 bit difference
    // has an unambiguous sign bit.
    assign w_upper     = {r_rem, r_quo[DATA_W-1]};
    assign w_trial     = w_upper - {1'b0, r_div};
    assign w_trial_neg = w_trial[DATA_W];

    // Sign correction applied in the SIGN state
    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs; cancel overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_valid     = (r_state == S_DONE);
                w_state_nxt = S_IDLE;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (w_b_zero) begin
                        w_state_nxt = S_SIGN;
                    end
`endif
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == c_LAST_STEP) begin
                    w_state_nxt = S_SIGN;
                end
            end
            S_SIGN: begin
                w_busy      = 1'b1;
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (bus.cancel) begin
            w_accept    = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    // Operand capture, iteration datapath and result load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_div   <= w_b_mag;
                r_cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
                if (w_b_zero) begin
                    // Same magnitudes the full iteration would produce
                    r_rem <= w_a_mag;
                    r_quo <= '1;
                end else begin
                    r_rem <= '0;
                    r_quo <= w_a_mag;
                end
`else
                r_rem <= '0;
                r_quo <= w_a_mag;
`endif
            end else if ((r_state == S_CALC) && !bus.cancel) begin
                r_rem <= w_trial_neg ? w_upper[DATA_W-1:0] : w_trial[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], ~w_trial_neg};
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == S_SIGN) && !bus.cancel) begin
                r_result <= {w_r_fix, w_q_fix};
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.result_valid = w_valid;
    assign bus.result       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 34;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_if #(.DATA_W(32)) dif ();

    div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic [31:0] av, input logic [31:0] bv);
        dif.is_signed = s;
        dif.a         = av;
        dif.b         = bv;
        dif.start     = 1'b1;
        tick();
        dif.start     = 1'b0;
    endtask

    // Returns the cycle (relative to the start cycle) in which result_valid appears
    task automatic wait_result(output int lat, output int busy_cyc);
        lat      = 1;
        busy_cyc = 0;
        while (!dif.result_valid && lat < 100) begin
            if (dif.busy) busy_cyc++;
            tick();
            lat++;
        end
    endtask

    task automatic op(input string tag, input logic s, input logic [31:0] av,
                      input logic [31:0] bv, input int exp_lat, input logic [63:0] exp_res);
        int lat;
        int bc;
        issue(s, av, bv);
        wait_result(lat, bc);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, dif.result, exp_res);
    endtask

    initial begin
        int lat;
        int bc;
        logic saw;
        rst           = 1'b1;
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.cancel    = 1'b0;
        #12;
        check("reset busy", 64'(dif.busy), 64'd0);
        check("reset valid", 64'(dif.result_valid), 64'd0);
        check("reset result", dif.result, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 100/7 unsigned with latency and busy duration
        issue(1'b0, 32'd100, 32'd7);
        wait_result(lat, bc);
        check("u100/7 latency", 64'(lat), 64'd34);
        check("u100/7 busy cycles", 64'(bc), 64'd33);
        check("u100/7 result", dif.result, {32'h0000_0002, 32'h0000_000E});
        tick();
        check("u100/7 valid pulse width", 64'(dif.result_valid), 64'd0);

        op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, {32'h0000_0001, 32'hFFFF_FFFD});
        op("s-min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'h0, 32'h8000_0000});
        op("uFFFFFFFF/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34, {32'h0, 32'hFFFF_FFFF});
        op("uMAX/0x80000001", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 34, {32'h7FFF_FFFE, 32'h1});
        op("u5/0", 1'b0, 32'd5, 32'd0, ZLAT, {32'h0000_0005, 32'hFFFF_FFFF});
        op("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, ZLAT, {32'hFFFF_FFFB, 32'h0000_0001});

        // Cancel in the middle of CALC
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) tick();
        dif.cancel = 1'b1;
        tick();
        dif.cancel = 1'b0;
        check("cancel busy", 64'(dif.busy), 64'd0);
        saw = 1'b0;
        repeat (40) begin
            if (dif.result_valid) saw = 1'b1;
            tick();
        end
        check("cancel no valid", 64'(saw), 64'd0);
        check("cancel result held", dif.result, {32'hFFFF_FFFB, 32'h0000_0001});

        // Start together with cancel is dropped
        dif.is_signed = 1'b0;
        dif.a         = 32'd9;
        dif.b         = 32'd4;
        dif.start     = 1'b1;
        dif.cancel    = 1'b1;
        tick();
        dif.start     = 1'b0;
        dif.cancel    = 1'b0;
        check("start+cancel busy", 64'(dif.busy), 64'd0);
        saw = 1'b0;
        repeat (40) begin
            if (dif.result_valid) saw = 1'b1;
            tick();
        end
        check("start+cancel no valid", 64'(saw), 64'd0);

        op("u9/4", 1'b0, 32'd9, 32'd4, 34, {32'h1, 32'h2});

        // Asynchronous reset mid-CALC
        issue(1'b0, 32'd100, 32'd7);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 64'(dif.busy), 64'd0);
        check("async rst valid", 64'(dif.result_valid), 64'd0);
        check("async rst result", dif.result, 64'd0);
        #1 rst = 1'b0;
        tick();

        // 12/3 followed by a start issued during its DONE cycle
        op("u12/3", 1'b0, 32'd12, 32'd3, 34, {32'h0, 32'h4});
        op("u20/6 back-to-back", 1'b0, 32'd20, 32'd6, 34, {32'h2, 32'h3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider serving the EX stage for DIV/DIVU.
- EX stage issues a request; this block computes quotient and remainder by radix-2 restoring division, then returns a 64-bit {remainder, quotient} packed in HI/LO layout, ready to write into the hilo register.
- Holds EX via busy; supports flush on exception through cancel.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- is_signed  input  1  1 = DIV semantics, 0 = DIVU; captured with start.
- a  input  DATA_W  dividend; captured with start.
- b  input  DATA_W  divisor; captured with start.
- cancel  input  1  flush; aborts any operation.
- busy  output  1  high in CALC and SIGN states.
- result_valid  output  1  one-cycle pulse in DONE.
- result  output  2*DATA_W  {remainder, quotient}; hi half = remainder, lo half = quotient.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, result_valid=0, result=0, iteration counter=0.
- States: IDLE, CALC, SIGN, DONE.
- IDLE/DONE with start=1 and cancel=0, on edge E:
  - Capture is_signed, sign of a, sign of b.
  - Capture |a| and |b|; magnitudes are taken only when is_signed=1.
  - Clear partial remainder; counter=0; go to CALC.
- CALC: one restoring step per edge.
  - Shift {rem, quo} left by 1.
  - Trial-subtract divisor magnitude from the upper bits, computed DATA_W+1 bits wide.
  - If result is non-negative, keep the difference and set quotient LSB=1; otherwise set LSB=0.
  - After DATA_W steps (edges E+1..E+DATA_W), go to SIGN.
- SIGN (edge E+DATA_W+1):
  - Quotient negated if is_signed and sign(a)^sign(b).
  - Remainder negated if is_signed and sign(a).
  - Load result; go to DONE.
- DONE: result_valid=1 for exactly one cycle (DATA_W+2 cycles after the start cycle; 34 for DATA_W=32).
  - Next state is IDLE, or CALC if start is asserted again.
- result holds its last value until the next SIGN load; it does not change on cancel.
- start in CALC/SIGN: ignored, no queuing.
- cancel=1 in any state: next edge goes to IDLE, busy=0, no result_valid. cancel wins over a simultaneous start.
- Signed overflow: 0x80000000 / -1 gives quotient 0x80000000, remainder 0, which is the natural result of the magnitude path. No exception is raised.
- Divide by zero, default:
  - Runs full latency.
  - Magnitude result is |q| = all ones, |r| = |a|; sign correction is then applied as normal.
  - Unsigned 5/0 gives hi=5, lo=0xFFFFFFFF.
  - Signed -5/0 gives lo=0x00000001, hi=0xFFFFFFFB.
- Rule for the EX stage: stall while busy=1 or (start issued and result_valid not yet seen).

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - On start with b==0, go directly to SIGN, loading the divide-by-zero magnitudes.
  - result_valid occurs 2 cycles after the start cycle.
  - Result values are identical to the default path.
- Undefined: divide by zero takes the full DATA_W+2 cycle latency.

Test Plan:
- Unsigned 100/7 (is_signed=0) -> result_valid exactly 34 cycles after start; hi=0x00000002, lo=0x0000000E; busy high for 33 cycles.
- Signed -7/2 (a=0xFFFFFFF9, b=2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000. Unsigned 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
- Unsigned 5/0 -> hi=5, lo=0xFFFFFFFF, valid after 34 cycles; with DIV_ZERO_FAST_EN, the same values after 2 cycles.
- Start 100/7, assert cancel at cycle 10 -> busy drops next cycle, no result_valid. Then start 9/4 together with cancel -> ignored. Restart 9/4 -> lo=2, hi=1, valid 34 cycles later.
- Assert rst asynchronously mid-CALC -> busy, result_valid and result go to 0 immediately. After release, start 12/3 -> lo=4, hi=0; back-to-back start in DONE is accepted.
